dmem_cache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller. It is the responder for the datapath's data-memory port: it accepts the datapath's memread/memwrite requests with aluout as address and writedata as store data, and returns readdata. It stalls the pipeline while it completes transactions on a multi-cycle req/ack main-memory bus. Word accesses only.

---
 rtl/dmem_cache_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_cache_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Answers the datapath's load/store port and stalls it across multi-cycle req/ack memory transactions.
module dmem_cache_ctrl #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);

  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [31:0]      r_fill;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_is_write;
  logic             w_is_read;
  logic [31:0]      w_word_addr;
  logic             w_unused;

  assign w_index     = cpu_addr[IDX_W+1:2];
  assign w_tag       = cpu_addr[31:IDX_W+2];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // A simultaneous read+write request is a write; the read flag is dropped.
  assign w_is_write  = cpu_memwrite;
  assign w_is_read   = cpu_memread && !cpu_memwrite;
  assign w_word_addr = {cpu_addr[31:2], 2'b00};
  assign w_unused    = ^cpu_addr[1:0];

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

  // Memory handshake: mem_req rises together with mem_we/mem_addr/mem_wdata and
  // all four hold until the one-cycle mem_ack pulse; reset may withdraw mem_req
  // without an ack, and an ack arriving while no request is open is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_fill      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_write) begin
            r_state     <= WR;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_word_addr;
            r_mem_wdata <= cpu_wdata;
          end else if (w_is_read && !w_hit) begin
            r_state     <= RD;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= w_word_addr;
            r_mem_wdata <= cpu_wdata;
          end
        end
        RD: begin
          if (mem_ack) begin
            r_state          <= DONE;
            r_mem_req        <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_fill           <= mem_rdata;
          end
        end
        WR: begin
          if (mem_ack) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; only the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (reset && mem_ack) begin
      if (r_state == RD) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_rdata;
      end else if (r_state == WR && w_hit) begin
        r_data[w_index] <= cpu_wdata;
      end
    end
  end

  // mem_we stays put after the ack, so in DONE it still tells a load from a store.
  always_comb begin
    stall     = 1'b0;
    cpu_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_is_write) begin
          stall = 1'b1;
        end else if (w_is_read) begin
          if (w_hit) begin
            cpu_rdata = r_data[w_index];
          end else begin
            stall = 1'b1;
          end
        end
      end
      RD, WR: begin
        stall = 1'b1;
      end
      DONE: begin
        if (!r_mem_we) begin
          cpu_rdata = r_fill;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Self-checking bench for dmem_cache_ctrl: directed test-plan steps, then random loads/stores
// checked against a line-by-word-address cache model and a sparse backing-memory model.
module tb_dmem_cache_ctrl;

  localparam int LINES = 16;

  logic        clk;
  logic        reset;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each line remembers which word address it holds.
  bit          m_valid [LINES];
  logic [29:0] m_line  [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] exp_q [$];

  dmem_cache_ctrl #(.LINES(LINES)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .o_dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Driver: one complete request, entered and left just after a rising edge.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input int k, input string nm);
    logic [29:0] wa;
    int          idx;
    bit          is_w;
    bit          is_r;
    bit          hit;
    logic [31:0] rv;
    wa   = addr[31:2];
    idx  = int'(wa % LINES);
    is_w = wr;
    is_r = rd && !wr;
    hit  = m_valid[idx] && (m_line[idx] == wa);
    cpu_memread  = rd;
    cpu_memwrite = wr;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    if (!is_w && !is_r) begin
      mem_ack = 1'b1;
      @(negedge clk);
      chk({nm, " idle stall"}, {31'd0, stall}, 32'd0);
      chk({nm, " idle rdata"}, cpu_rdata, 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk({nm, " stray ack req"}, {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
    end else if (is_r && hit) begin
      exp_q.push_back(m_data[idx]);
      @(negedge clk);
      chk({nm, " hit stall"}, {31'd0, stall}, 32'd0);
      chk({nm, " hit rdata"}, cpu_rdata, exp_q.pop_front());
      @(posedge clk); #1;
    end else begin
      if (is_r) begin
        if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
        rv = mem_model[wa];
      end else begin
        rv = $urandom;
      end
      @(negedge clk);
      chk({nm, " c0 stall"}, {31'd0, stall}, 32'd1);
      chk({nm, " c0 req"}, {31'd0, mem_req}, 32'd0);
      chk({nm, " c0 rdata"}, cpu_rdata, 32'd0);
      for (int c = 1; c <= k; c++) begin
        @(posedge clk); #1;
        if (c == k) begin
          mem_ack   = 1'b1;
          mem_rdata = rv;
        end
        @(negedge clk);
        chk({nm, " busy stall"}, {31'd0, stall}, 32'd1);
        chk({nm, " busy req"}, {31'd0, mem_req}, 32'd1);
        chk({nm, " busy we"}, {31'd0, mem_we}, {31'd0, is_w});
        chk({nm, " busy addr"}, mem_addr, {addr[31:2], 2'b00});
        if (is_w) chk({nm, " busy wdata"}, mem_wdata, wdata);
        chk({nm, " busy rdata"}, cpu_rdata, 32'd0);
      end
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (is_r) begin
        m_valid[idx] = 1'b1;
        m_line[idx]  = wa;
        m_data[idx]  = rv;
        exp_q.push_back(rv);
      end else begin
        mem_model[wa] = wdata;
        if (hit) m_data[idx] = wdata;
      end
      @(negedge clk);
      chk({nm, " done stall"}, {31'd0, stall}, 32'd0);
      chk({nm, " done req"}, {31'd0, mem_req}, 32'd0);
      chk({nm, " done rdata"}, cpu_rdata, is_r ? exp_q.pop_front() : 32'd0);
      @(posedge clk); #1;
    end
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    reset        = 1'b0;
    model_invalidate();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst req", {31'd0, mem_req}, 32'd0);
    chk("rst we", {31'd0, mem_we}, 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed test plan
    mem_model[30'h10] = 32'hDEADBEEF;
    access(0, 1, 32'h40, 32'h0, 3, "rd40 miss");
    access(0, 1, 32'h40, 32'h0, 1, "rd40 hit");
    access(0, 1, 32'h80, 32'h0, 2, "rd80 conflict");
    access(0, 1, 32'h40, 32'h0, 1, "rd40 refill");
    access(1, 0, 32'h40, 32'h12345678, 2, "wr40 hit");
    access(0, 1, 32'h40, 32'h0, 1, "rd40 after wr");
    chk("rd40 model data", m_data[0], 32'h12345678);
    access(1, 0, 32'h100, 32'hA5A5_0100, 1, "wr100 miss");
    access(0, 1, 32'h100, 32'h0, 1, "rd100 no alloc");
    access(1, 1, 32'h44, 32'hCAFE_0044, 2, "rd+wr as wr");
    access(0, 1, 32'h44, 32'h0, 1, "rd44 after both");

    // Reset in the middle of a read miss
    access(0, 1, 32'h40, 32'h0, 1, "rd40 pre-reset");
    cpu_memread = 1'b1;
    cpu_addr    = 32'h204;
    @(negedge clk);
    chk("rstmid c0 stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid c1 req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    reset       = 1'b0;
    cpu_memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_invalidate();
    @(negedge clk);
    chk("rstmid req", {31'd0, mem_req}, 32'd0);
    chk("rstmid we", {31'd0, mem_we}, 32'd0);
    chk("rstmid addr", mem_addr, 32'd0);
    chk("rstmid stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late ack req", {31'd0, mem_req}, 32'd0);
    chk("late ack stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    access(0, 1, 32'h40, 32'h0, 2, "rd40 post-reset");

    // Random traffic over a small address pool so lines hit, conflict and get rewritten
    for (int n = 0; n < 250; n++) begin
      a  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, LINES - 1) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op == 0)      access(0, 0, a, $urandom, 1, "rnd none");
      else if (op <= 5) access(0, 1, a, $urandom, $urandom_range(1, 4), "rnd rd");
      else if (op <= 8) access(1, 0, a, $urandom, $urandom_range(1, 4), "rnd wr");
      else              access(1, 1, a, $urandom, $urandom_range(1, 4), "rnd both");
    end

    chk("exp_q drained", exp_q.size(), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
